mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 200 ++++++++++++++++++++
 tb/tb_mul_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq -- microprogram-style sequencer for an unsigned shift-and-add
// multiply on an external bit-slice datapath.
//
// The sequencer drives ALU / shift instructions and register addresses. The
// datapath holds the multiplicand in R[A], accumulates the high product half
// in R[B] and shifts the multiplier / low product half through Q.
//
// Sequence: IDLE -> LOADQ -> CLR -> STEP x N -> DONE -> IDLE.
// N is 64 for a 64-bit multiply and 32 for a 32-bit multiply.
//
// Optional feature: define MULSEQ_ABORT_EN to add the abort input. When it is
// set, abort cancels a running operation (LOADQ/CLR/STEP) with no done pulse.
//
// Parameters
//   ISS_SHR   status/shift code for the double-length right shift used in STEP
//   ISS_HOLD  status/shift code for no shift, used in every other state
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous, active-high
//   start     request a multiply (sampled only in IDLE)
//   ra_mcand  multiplicand register address (latched at start)
//   rb_acc    accumulator register address (latched at start)
//   half      1 = 32-bit, 0 = 64-bit (latched at start)
//   CT        datapath conditional test (Q LSB during STEP)
//   abort     cancel request (MULSEQ_ABORT_EN builds only)
//   Ialu      ALU instruction {dest[8:6], func[5:3], src[2:0]}
//   A, B      datapath register addresses
//   C0        datapath carry-in (always 0)
//   Iss       status/shift instruction
//   nCEM      machine status enable, active-low (always 1)
//   nCEN      micro status enable, active-low (0 only in STEP)
//   mode32    latched half, to the datapath
//   load_d    D bus must carry the multiplier (LOADQ)
//   busy      operation in progress (LOADQ, CLR, STEP)
//   done      one-cycle completion pulse (DONE)
// ---------------------------------------------------------------------------
module mul_seq #(
    parameter logic [12:0] ISS_SHR  = 13'h0,
    parameter logic [12:0] ISS_HOLD = 13'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ra_mcand,
    input  logic [3:0]  rb_acc,
    input  logic        half,
    input  logic        CT,
`ifdef MULSEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [8:0]  Ialu,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic        C0,
    output logic [12:0] Iss,
    output logic        nCEM,
    output logic        nCEN,
    output logic        mode32,
    output logic        load_d,
    output logic        busy,
    output logic        done
);

    // ALU instruction codes
    localparam logic [8:0] IALU_NOP    = 9'h05B;  // no register write
    localparam logic [8:0] IALU_LOADQ  = 9'h01F;  // Q <= D
    localparam logic [8:0] IALU_CLR    = 9'h0E3;  // R[B] <= 0
    localparam logic [8:0] IALU_ADD    = 9'h101;  // R[B] + R[A], RAMQD
    localparam logic [8:0] IALU_PASS   = 9'h11B;  // R[B] pass,   RAMQD

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADQ = 3'd1,
        CLR   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] count;
    logic [5:0] count_nxt;
    logic       last_step;
    logic       accept;
    logic       cancel;

    // Last step index depends on the latched width, never on the live input.
    assign last_step = (count == (mode32 ? 6'd31 : 6'd63));
    assign accept    = (state == IDLE) && start;

`ifdef MULSEQ_ABORT_EN
    assign cancel = abort && ((state == LOADQ) || (state == CLR) || (state == STEP));
`else
    assign cancel = 1'b0;
`endif

    // State and step counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 6'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Operand addresses and width are captured once, on the accepting edge,
    // so later changes on ra_mcand/rb_acc/half cannot disturb an operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A      <= 4'd0;
            B      <= 4'd0;
            mode32 <= 1'b0;
        end else if (accept) begin
            A      <= ra_mcand;
            B      <= rb_acc;
            mode32 <= half;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                count_nxt = 6'd0;
                if (start) begin
                    state_nxt = LOADQ;
                end
            end
            LOADQ: begin
                state_nxt = CLR;
            end
            CLR: begin
                state_nxt = STEP;
                count_nxt = 6'd0;
            end
            STEP: begin
                if (last_step) begin
                    state_nxt = DONE;
                    count_nxt = 6'd0;
                end else begin
                    count_nxt = count + 6'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = 6'd0;
            end
        endcase
        if (cancel) begin
            state_nxt = IDLE;
            count_nxt = 6'd0;
        end
    end

    // Output decode; CT reaches Ialu combinationally only in STEP.
    always_comb begin
        Ialu   = IALU_NOP;
        Iss    = ISS_HOLD;
        nCEN   = 1'b1;
        load_d = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            LOADQ: begin
                Ialu   = IALU_LOADQ;
                load_d = 1'b1;
                busy   = 1'b1;
            end
            CLR: begin
                Ialu = IALU_CLR;
                busy = 1'b1;
            end
            STEP: begin
                Ialu = CT ? IALU_ADD : IALU_PASS;
                Iss  = ISS_SHR;
                nCEN = 1'b0;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                Ialu = IALU_NOP;
            end
        endcase
    end

    assign C0   = 1'b0;
    assign nCEM = 1'b1;

endmodule

// File: tb/tb_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_seq -- self-checking bench for mul_seq.
//
// A small behavioural datapath (register file, Q register, D bus) executes the
// sequencer's instructions so that CT is realistic and the final product can
// be compared against a plain multiplication of the operands.
// ---------------------------------------------------------------------------
module tb_mul_seq;

    localparam logic [12:0] SHR  = 13'h1A5;
    localparam logic [12:0] HOLD = 13'h0C3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ra_mcand;
    logic [3:0]  rb_acc;
    logic        half;
    logic        CT;
`ifdef MULSEQ_ABORT_EN
    logic        abort;
`endif
    logic [8:0]  Ialu;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        C0;
    logic [12:0] Iss;
    logic        nCEM;
    logic        nCEN;
    logic        mode32;
    logic        load_d;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;
    int ncen_low;

    mul_seq #(.ISS_SHR(SHR), .ISS_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ra_mcand(ra_mcand), .rb_acc(rb_acc), .half(half), .CT(CT),
`ifdef MULSEQ_ABORT_EN
        .abort(abort),
`endif
        .Ialu(Ialu), .A(A), .B(B), .C0(C0), .Iss(Iss),
        .nCEM(nCEM), .nCEN(nCEN), .mode32(mode32), .load_d(load_d),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural datapath ----------------
    logic [63:0] rf [16];
    logic [63:0] q;
    logic [63:0] dbus;
    logic        pre_req;
    logic [3:0]  pre_idx;
    logic [63:0] pre_val;
    logic [8:0]  s_ialu;
    logic [12:0] s_iss;
    logic [3:0]  s_a, s_b;
    logic        s_m32, s_ld;

    assign CT = q[0];

    always @(negedge clk) begin
        s_ialu = Ialu; s_iss = Iss; s_a = A; s_b = B; s_m32 = mode32; s_ld = load_d;
    end

    always @(posedge clk) begin : dp
        logic [64:0] sum;
        logic [63:0] msk;
        msk = s_m32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        if (pre_req) rf[pre_idx] = pre_val;
        if (!reset) begin
            case (s_ialu)
                9'h01F: if (s_ld) q = dbus & msk;
                9'h0E3: rf[s_b] = 64'd0;
                9'h101, 9'h11B: begin
                    sum = {1'b0, rf[s_b] & msk}
                        + ((s_ialu == 9'h101) ? {1'b0, rf[s_a] & msk} : 65'd0);
                    if (s_iss == SHR) begin
                        if (s_m32) begin
                            rf[s_b] = {32'd0, sum[32:1]};
                            q       = {32'd0, sum[0], q[31:1]};
                        end else begin
                            rf[s_b] = sum[64:1];
                            q       = {sum[0], q[63:1]};
                        end
                    end else begin
                        rf[s_b] = sum[63:0] & msk;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] obs_t();
        return {Ialu, Iss, nCEN, nCEM, C0, busy, done, load_d, mode32, A, B};
    endfunction

    localparam logic [36:0] IDLE_T = {9'h05B, HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

    // Expected outputs k cycles after the accepting edge:
    // 1 LOADQ, 2 CLR, 3..n+2 STEP (step i sees multiplier bit i), n+3 DONE, n+4 IDLE.
    function automatic logic [36:0] exp_t(input int k, input int n, input logic [63:0] ml,
                                          input logic [3:0] ra, input logic [3:0] rb, input logic h);
        logic [8:0]  ia;
        logic [12:0] is;
        logic        cen, bz, dn, ld;
        ia = 9'h05B; is = HOLD; cen = 1'b1; bz = 1'b0; dn = 1'b0; ld = 1'b0;
        if (k == 1) begin
            ia = 9'h01F; ld = 1'b1; bz = 1'b1;
        end else if (k == 2) begin
            ia = 9'h0E3; bz = 1'b1;
        end else if (k <= n + 2) begin
            ia = ml[k-3] ? 9'h101 : 9'h11B; is = SHR; cen = 1'b0; bz = 1'b1;
        end else if (k == n + 3) begin
            dn = 1'b1;
        end
        return {ia, is, cen, 1'b1, 1'b0, bz, dn, ld, h, ra, rb};
    endfunction

    // One full multiply. hold keeps start high so the next operation is
    // accepted in the IDLE cycle; prestarted means that accept already happened.
    task automatic run_op(input logic [63:0] mc, input logic [63:0] ml, input logic h,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input bit hold, input bit prestarted);
        int           n;
        logic [63:0]  msk, hi, lo;
        logic [127:0] p;
        logic [36:0]  m;
        n   = h ? 32 : 64;
        msk = h ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        ncen_low = 0;
        if (!prestarted) begin
            pre_idx = ra; pre_val = mc & msk; pre_req = 1'b1;
            ra_mcand = ra; rb_acc = rb; half = h; dbus = ml; start = 1'b1;
        end
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                pre_req = 1'b0;
                start   = hold;
            end
            m = (k == n + 4) ? ~37'h1FF : '1;
            chk($sformatf("seq_k%0d_n%0d", k, n), 64'(obs_t() & m),
                64'(exp_t(k, n, ml, ra, rb, h) & m));
            if (nCEN == 1'b0) ncen_low++;
            if (k == n + 3) begin
                p = {64'd0, mc & msk} * {64'd0, ml & msk};
                if (h) begin
                    hi = {32'd0, p[63:32]}; lo = {32'd0, p[31:0]};
                end else begin
                    hi = p[127:64]; lo = p[63:0];
                end
                chk("product_hi", rf[rb], hi);
                chk("product_lo", q, lo);
            end
            if (k <= n + 1) begin
                ra_mcand = 4'($urandom); rb_acc = 4'($urandom); half = 1'($urandom);
            end else begin
                ra_mcand = ra; rb_acc = rb; half = h;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0]  ra, rb;
        logic [63:0] mc, ml;
        logic        h;
        vectors = 0; miscompares = 0; ncen_low = 0;
        reset = 1'b1; start = 1'b0; ra_mcand = 4'd0; rb_acc = 4'd0; half = 1'b0;
        dbus = 64'd0; pre_req = 1'b0; pre_idx = 4'd0; pre_val = 64'd0;
`ifdef MULSEQ_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 64'(obs_t()), 64'(IDLE_T));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(obs_t()), 64'(IDLE_T));

        // 64-bit 3 x 5
        run_op(64'd3, 64'd5, 1'b0, 4'd1, 4'd2, 0, 0);
        // 32-bit all-ones squared
        run_op(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 4'd3, 4'd4, 0, 0);
        // multiplier zero: only pass steps, nCEN low exactly N cycles
        run_op(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 4'd5, 4'd6, 0, 0);
        chk("ncen_low_64", 64'(ncen_low), 64'd64);
        run_op(64'hDEAD_BEEF, 64'd0, 1'b1, 4'd7, 4'd8, 0, 0);
        chk("ncen_low_32", 64'(ncen_low), 64'd32);

        // randomized operands and widths
        for (int t = 0; t < 4; t++) begin
            ra = 4'($urandom);
            rb = ra + 4'(1 + $urandom_range(0, 14));
            mc = {$urandom, $urandom};
            ml = {$urandom, $urandom};
            h  = 1'($urandom);
            run_op(mc, ml, h, ra, rb, 0, 0);
        end

        // start held: back-to-back operations with one IDLE cycle between them
        run_op(64'd9, 64'd7, 1'b1, 4'd9, 4'd10, 1, 0);
        run_op(64'd9, 64'd7, 1'b1, 4'd9, 4'd10, 0, 1);

        // reset in the middle of step 10
        pre_idx = 4'd1; pre_val = 64'd11; pre_req = 1'b1;
        ra_mcand = 4'd1; rb_acc = 4'd2; half = 1'b0; dbus = 64'hFFFF; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; pre_req = 1'b0; end
        end
        chk("step10_iss", 64'(Iss), 64'(SHR));
        #2 reset = 1'b1;
        #1 chk("reset_mid_op", 64'(obs_t()), 64'(IDLE_T));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", 64'(obs_t()), 64'(IDLE_T));
        end
        run_op(64'd1000, 64'd77, 1'b0, 4'd11, 4'd12, 0, 0);

`ifdef MULSEQ_ABORT_EN
        // abort at step 5
        pre_idx = 4'd1; pre_val = 64'd5; pre_req = 1'b1;
        ra_mcand = 4'd1; rb_acc = 4'd2; half = 1'b1; dbus = 64'h3; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; pre_req = 1'b0; end
        end
        chk("abort_step5_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 64'({Ialu, Iss, nCEN, busy, done, load_d}),
            64'({9'h05B, HOLD, 1'b1, 1'b0, 1'b0, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", 64'({busy, done}), 64'd0);
        end
        run_op(64'd6, 64'd7, 1'b1, 4'd1, 4'd2, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
